// File: rtl/matmul_feeder_pkg.sv
// Shared types for the matrix-multiply feeder and the accelerator ports.
package matmul_pkg;

  localparam int MAX_ELEMS = 1024;

  typedef logic [7:0] elem_t;

  typedef elem_t [MAX_ELEMS-1:0] mat_t;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    DRAIN
  } state_t;

endpackage

// File: rtl/matmul_feeder_if.sv
// Byte-wide valid/ready stream used for the operand input and the result output.
interface matmul_feeder_if;
  import matmul_pkg::*;

  elem_t data;
  logic  valid;
  logic  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/matmul_feeder.sv
// Sequencer that loads operands A and B from a byte stream, kicks the
// accelerator, waits (with timeout) for done and streams the result bytes out.
module matmul_feeder
  import matmul_pkg::*;
#(
  parameter int MAT_SIZE = 2,
  parameter int DAT_SIZE = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic  clk,
  input  logic  rst_n,
  matmul_feeder_if.slave  in_s,
  matmul_feeder_if.master out_s,
  output logic  start_o,
  input  logic  done_i,
  output mat_t  mat_A_o,
  output mat_t  mat_B_o,
  input  mat_t  mat_C_i,
  output logic  busy_o,
  output logic  err_o
);

  localparam int E     = MAT_SIZE * MAT_SIZE;
  localparam int IDX_W = (E > 1) ? $clog2(E + 1) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(E - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [TMR_W-1:0]      timer;
  mat_t                  a_q;
  mat_t                  b_q;
  mat_t                  c_q;
  logic                  start_q;
  logic                  out_valid_q;
  elem_t                 out_data_q;
  logic                  err_q;
  logic [DAT_SIZE-1:0]   in_byte;
  logic                  unused_c_bits;

  assign in_byte = in_s.data;

  // Only the low E result entries are captured; the rest of the bus is ignored.
  assign unused_c_bits = ^mat_C_i;

  // Main sequencer: buffers, index, timer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD_A;
      idx         <= '0;
      timer       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        LOAD_A: begin
          if (in_s.valid) begin
            a_q[idx] <= in_byte;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= LOAD_B;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end
        LOAD_B: begin
          if (in_s.valid) begin
            b_q[idx] <= in_byte;
            if (idx == IDX_LAST) begin
              idx     <= '0;
              start_q <= 1'b1;
              state   <= START;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + TMR_ONE;
          if (done_i) begin
            for (int i = 0; i < E; i++) begin
              c_q[i] <= mat_C_i[i];
            end
            idx         <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= mat_C_i[0];
            state       <= DRAIN;
          end else if (timer == TMR_LAST) begin
            err_q <= 1'b1;
            idx   <= '0;
            state <= LOAD_A;
          end
        end
        DRAIN: begin
          if (out_s.ready) begin
            if (idx == IDX_LAST) begin
              out_valid_q <= 1'b0;
              idx         <= '0;
              state       <= LOAD_A;
            end else begin
              idx        <= idx + IDX_ONE;
              out_data_q <= c_q[idx + IDX_ONE];
            end
          end
        end
        default: begin
          idx   <= '0;
          state <= LOAD_A;
        end
      endcase
    end
  end

  assign in_s.ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_s.valid = out_valid_q;
  assign out_s.data  = out_data_q;
  assign start_o     = start_q;
  assign err_o       = err_q;
  assign busy_o      = !((state == LOAD_A) && (idx == '0));
  assign mat_A_o     = a_q;
  assign mat_B_o     = b_q;

endmodule
